// File: rtl/uart_rx_fifo.sv
// UART receiver (16x oversampled, majority-voted bits) feeding a first-word
// fall-through receive FIFO with overrun and framing-error pulses.
module uart_rx_fifo #(
  parameter int CLK_HZ = 48000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 8
) (
  input  logic                     clk_48mhz,
  input  logic                     reset_n,
  input  logic                     uart_rx_in,
  input  logic                     rd_en,
  output logic [7:0]               rx_data,
  output logic                     rx_empty,
  output logic                     rx_full,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     frame_err,
  output logic                     overrun,
  output logic                     busy
);

  localparam int DIV   = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int DIV_W = $clog2(DIV + 1);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d, sync2_q, sync2_d, rx_prev_q, rx_prev_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [4:0]        tick_cnt_q, tick_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic              s7_q, s7_d, s8_q, s8_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic [7:0]        mem_q [DEPTH];

  logic rx_s, fall, tick, maj, push, bad_stop, pop, wr_ok, full_now;

  assign rx_s = sync2_q;
  assign fall = rx_prev_q & ~rx_s;
  assign tick = (div_q == DIV_W'(DIV - 1));
  assign maj  = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);

  // State register
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (fall) state_d = START;
      START:     if (tick && tick_cnt_q == 5'd7) state_d = rx_s ? IDLE : DATA;
      DATA:      if (tick && tick_cnt_q == 5'd15 && bit_idx_q == 3'd7) state_d = STOP;
      STOP:      if (tick && tick_cnt_q == 5'd8) state_d = maj ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (tick && rx_s && tick_cnt_q == 5'd15) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != IDLE);
    push     = (state_q == STOP) && tick && (tick_cnt_q == 5'd8) && maj;
    bad_stop = (state_q == STOP) && tick && (tick_cnt_q == 5'd8) && !maj;
  end

  // Bit timing, sampling and shift register
  always_comb begin
    sync1_d    = uart_rx_in;
    sync2_d    = sync1_q;
    rx_prev_d  = rx_s;
    div_d      = (state_q == IDLE || tick) ? '0 : div_q + DIV_W'(1);
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    s7_d       = s7_q;
    s8_d       = s8_q;
    shreg_d    = shreg_q;
    unique case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        bit_idx_d  = '0;
      end
      START: if (tick) begin
        // 24 acts as -8: data bit 0 begins 8 ticks after the start-bit centre
        tick_cnt_d = (tick_cnt_q == 5'd7) ? 5'd24 : tick_cnt_q + 5'd1;
      end
      DATA, STOP: if (tick) begin
        if (tick_cnt_q == 5'd6) s7_d = rx_s;
        if (tick_cnt_q == 5'd7) s8_d = rx_s;
        if (tick_cnt_q == 5'd8 && state_q == DATA) shreg_d = {maj, shreg_q[7:1]};
        if (tick_cnt_q == 5'd15) begin
          tick_cnt_d = '0;
          bit_idx_d  = bit_idx_q + 3'd1;
        end else if (state_q == STOP && tick_cnt_q == 5'd8) begin
          tick_cnt_d = '0;
        end else begin
          tick_cnt_d = tick_cnt_q + 5'd1;
        end
      end
      WAIT_IDLE: if (tick) tick_cnt_d = rx_s ? tick_cnt_q + 5'd1 : 5'd0;
      default: tick_cnt_d = '0;
    endcase
  end

  // Receive FIFO
  always_comb begin
    full_now    = (count_q == CW'(DEPTH));
    pop         = rd_en && (count_q != '0);
    wr_ok       = push && (!full_now || pop);
    overrun_d   = push && full_now && !pop;
    frame_err_d = bad_stop;
    wr_ptr_d    = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({wr_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      div_q       <= '0;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      rx_prev_q   <= rx_prev_d;
      div_q       <= div_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge clk_48mhz) begin
    s7_q    <= s7_d;
    s8_q    <= s8_d;
    shreg_q <= shreg_d;
    if (wr_ok) mem_q[wr_ptr_q] <= shreg_q;
  end

  assign rx_data   = mem_q[rd_ptr_q];
  assign rx_empty  = (count_q == '0);
  assign rx_full   = (count_q == CW'(DEPTH));
  assign rx_count  = count_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames at 115200 baud on a 48 MHz clock.
module tb_uart_rx_fifo;

  localparam int BIT_CLKS = 417;

  logic       clk = 1'b0;
  logic       reset_n, uart_rx_in, rd_en;
  logic [7:0] rx_data;
  logic       rx_empty, rx_full, frame_err, overrun, busy;
  logic [3:0] rx_count;

  int checks = 0, failures = 0;
  int fe_cnt = 0, ov_cnt = 0;
  logic [7:0] head_at_pop;

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk_48mhz (clk),
    .reset_n   (reset_n),
    .uart_rx_in(uart_rx_in),
    .rd_en     (rd_en),
    .rx_data   (rx_data),
    .rx_empty  (rx_empty),
    .rx_full   (rx_full),
    .rx_count  (rx_count),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Push lands on the 3981st rising edge after the start-bit drive; rd_en covers that edge.
  task automatic send_byte(input logic [7:0] b, input logic stop, input bit pop_at_push);
    uart_rx_in = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      uart_rx_in = b[i];
      wait_clks(BIT_CLKS);
    end
    uart_rx_in = stop;
    if (pop_at_push) begin
      wait_clks(227);
      head_at_pop = rx_data;
      rd_en = 1'b1;
      wait_clks(1);
      rd_en = 1'b0;
      wait_clks(BIT_CLKS - 228);
    end else begin
      wait_clks(BIT_CLKS);
    end
    uart_rx_in = 1'b1;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] exp);
    chk(tag, int'(rx_data), int'(exp));
    rd_en = 1'b1;
    wait_clks(1);
    rd_en = 1'b0;
  endtask

  initial begin
    uart_rx_in = 1'b1;
    rd_en      = 1'b0;
    reset_n    = 1'b0;
    wait_clks(3);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_empty", int'(rx_empty), 1);
    chk("rst_full",  int'(rx_full), 0);
    chk("rst_count", int'(rx_count), 0);
    chk("rst_fe",    int'(frame_err), 0);
    chk("rst_ov",    int'(overrun), 0);
    reset_n = 1'b1;
    wait_clks(10);

    // single good byte
    send_byte(8'hA5, 1'b1, 1'b0);
    chk("a5_empty", int'(rx_empty), 0);
    chk("a5_data",  int'(rx_data), 'hA5);
    chk("a5_count", int'(rx_count), 1);
    chk("a5_busy",  int'(busy), 0);
    chk("a5_fe",    fe_cnt, 0);
    chk("a5_ov",    ov_cnt, 0);
    read_chk("a5_read", 8'hA5);
    chk("a5_empty_after", int'(rx_empty), 1);

    // pop on empty is ignored
    rd_en = 1'b1;
    wait_clks(1);
    rd_en = 1'b0;
    chk("underflow_count", int'(rx_count), 0);
    chk("underflow_empty", int'(rx_empty), 1);

    // 4-clock glitch
    uart_rx_in = 1'b0;
    wait_clks(4);
    uart_rx_in = 1'b1;
    wait_clks(96);
    chk("glitch_busy_hi", int'(busy), 1);
    wait_clks(112);
    chk("glitch_busy_lo", int'(busy), 0);
    chk("glitch_empty",   int'(rx_empty), 1);
    chk("glitch_fe",      fe_cnt, 0);
    chk("glitch_ov",      ov_cnt, 0);
    wait_clks(50);

    // bad stop bit, then line high
    send_byte(8'h3C, 1'b0, 1'b0);
    chk("fe_pulse",    fe_cnt, 1);
    chk("fe_busy0",    int'(busy), 1);
    chk("fe_empty",    int'(rx_empty), 1);
    wait_clks(380);
    chk("fe_busy1",    int'(busy), 1);
    wait_clks(80);
    chk("fe_busy2",    int'(busy), 0);
    chk("fe_once",     fe_cnt, 1);
    chk("fe_count",    int'(rx_count), 0);
    wait_clks(20);

    // fill to DEPTH, then one more byte overruns
    for (int i = 0; i < 8; i++) send_byte(8'(i), 1'b1, 1'b0);
    chk("fill_full",  int'(rx_full), 1);
    chk("fill_count", int'(rx_count), 8);
    chk("fill_ov",    ov_cnt, 0);
    send_byte(8'h08, 1'b1, 1'b0);
    chk("ovr_pulse",  ov_cnt, 1);
    chk("ovr_count",  int'(rx_count), 8);
    chk("ovr_full",   int'(rx_full), 1);

    // full FIFO: pop in the same cycle as the 0x55 push
    send_byte(8'h55, 1'b1, 1'b1);
    chk("pp_head",   int'(head_at_pop), 'h00);
    chk("pp_ov",     ov_cnt, 1);
    chk("pp_count",  int'(rx_count), 8);
    chk("pp_full",   int'(rx_full), 1);
    for (int i = 1; i < 8; i++) read_chk("pp_read", 8'(i));
    read_chk("pp_last", 8'h55);
    chk("pp_empty",  int'(rx_empty), 1);
    chk("pp_count0", int'(rx_count), 0);

    // reset in the middle of a frame with bytes queued
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    send_byte(8'h33, 1'b1, 1'b0);
    chk("q3_count", int'(rx_count), 3);
    uart_rx_in = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      uart_rx_in = (i % 2 == 0);
      wait_clks(BIT_CLKS);
    end
    uart_rx_in = 1'b1;
    wait_clks(200);
    chk("mid_busy", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("mr_busy",  int'(busy), 0);
    chk("mr_empty", int'(rx_empty), 1);
    chk("mr_full",  int'(rx_full), 0);
    chk("mr_count", int'(rx_count), 0);
    chk("mr_fe",    int'(frame_err), 0);
    chk("mr_ov",    int'(overrun), 0);
    wait_clks(5);
    reset_n = 1'b1;
    wait_clks(20);
    send_byte(8'h81, 1'b1, 1'b0);
    chk("post_data",  int'(rx_data), 'h81);
    chk("post_count", int'(rx_count), 1);
    chk("post_fe",    fe_cnt, 1);
    chk("post_ov",    ov_cnt, 1);
    read_chk("post_read", 8'h81);
    chk("post_empty", int'(rx_empty), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
